// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, default widths
// and the one-hot phase strobe constants.
package pc_seq_pkg;

    localparam int DEF_PC_W = 8;
    localparam int DEF_IR_W = 8;
    localparam int NUM_PH   = 5;

    // Phase strobes packed as {clk5, clk4, clk3, clk2, clk1}
    localparam logic [NUM_PH-1:0] PH_NONE = 5'b00000;
    localparam logic [NUM_PH-1:0] PH1     = 5'b00001;
    localparam logic [NUM_PH-1:0] PH2     = 5'b00010;
    localparam logic [NUM_PH-1:0] PH3     = 5'b00100;
    localparam logic [NUM_PH-1:0] PH4     = 5'b01000;
    localparam logic [NUM_PH-1:0] PH5     = 5'b10000;

    typedef enum logic [1:0] {
        WAIT_PH1 = 2'd0,
        RUN      = 2'd1,
        HALTED   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_fetch_seq_phase_check.sv
// Combinational strobe checker: flags more than one strobe high and a
// single strobe that is not the successor of the last accepted phase.
module phase_check
    import pc_seq_pkg::*;
(
    input  logic [NUM_PH-1:0] strb,
    input  logic [NUM_PH-1:0] last_ph,
    output logic              any_hi,
    output logic              multi_hi,
    output logic              order_err
);

    logic [NUM_PH-1:0] exp_ph;

    // Successor phase is a left rotate of the last accepted one (clk5 -> clk1)
    assign exp_ph    = {last_ph[NUM_PH-2:0], last_ph[NUM_PH-1]};
    assign any_hi    = |strb;
    // Clearing the lowest set bit leaves something only when two or more are set
    assign multi_hi  = |(strb & (strb - NUM_PH'(1)));
    assign order_err = any_hi && !multi_hi && (strb != exp_ph);

endmodule

// File: rtl/pc_fetch_seq.sv
// Five-phase instruction fetch sequencer: fetch address on clk1, memory read
// on clk3, branch capture on clk4, PC update and retire on clk5.
module pc_fetch_seq
    import pc_seq_pkg::*;
#(
    parameter int             PC_W     = DEF_PC_W,
    parameter int             IR_W     = DEF_IR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            clk1,
    input  logic            clk2,
    input  logic            clk3,
    input  logic            clk4,
    input  logic            clk5,
    input  logic [IR_W-1:0] mem_data,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_addr,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    output logic [IR_W-1:0] ir,
    output logic            ir_valid,
    output logic [15:0]     retired,
    output logic            phase_err
);

    seq_state_t        state, state_nx;
    logic [NUM_PH-1:0] strb, last_ph;
    logic              any_hi, multi_hi, order_err;
    logic              accept, do_fetch, do_rd, do_load, do_cap, do_retire, do_err;
    logic              pend_en;
    logic [PC_W-1:0]   pend_addr;

    assign strb = {clk5, clk4, clk3, clk2, clk1};

    phase_check u_phase_check (
        .strb      (strb),
        .last_ph   (last_ph),
        .any_hi    (any_hi),
        .multi_hi  (multi_hi),
        .order_err (order_err)
    );

    // State register; reset drops any instruction in flight
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= WAIT_PH1;
        else     state <= state_nx;
    end

    // Next state and per-phase action decode
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        do_fetch  = 1'b0;
        do_rd     = 1'b0;
        do_load   = 1'b0;
        do_cap    = 1'b0;
        do_retire = 1'b0;
        do_err    = 1'b0;
        case (state)
            WAIT_PH1: begin
                if (multi_hi) begin
                    do_err = 1'b1;
                end else if (strb == PH1) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                    do_fetch = 1'b1;
                end
            end
            RUN: begin
                if (multi_hi || order_err) begin
                    // Abandon the instruction; pc/retired are untouched
                    do_err   = 1'b1;
                    state_nx = WAIT_PH1;
                end else if (any_hi) begin
                    accept    = 1'b1;
                    do_fetch  = (strb == PH1);
                    do_rd     = (strb == PH2);
                    do_load   = (strb == PH3);
                    do_cap    = (strb == PH4);
                    do_retire = (strb == PH5);
                    if (strb == PH5 && halt) state_nx = HALTED;
                end
            end
            HALTED: begin
                if (resume) state_nx = WAIT_PH1;
            end
            default: state_nx = WAIT_PH1;
        endcase
    end

    // Datapath registers driven by the decoded phase actions
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            last_ph   <= PH5;
            pc        <= RESET_PC;
            mem_addr  <= RESET_PC;
            mem_rd    <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pend_en   <= 1'b0;
            pend_addr <= '0;
            retired   <= '0;
            phase_err <= 1'b0;
        end else begin
            mem_rd   <= do_rd;
            ir_valid <= do_load;
            if (accept)   last_ph  <= strb;
            if (do_fetch) mem_addr <= pc;
            if (do_load)  ir       <= mem_data;
            if (do_cap) begin
                pend_en   <= branch_en;
                pend_addr <= branch_addr;
            end
            if (do_retire) begin
                pc      <= pend_en ? pend_addr : pc + PC_W'(1);
                retired <= retired + 16'd1;
            end
            if (do_err) phase_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: clean frames, branch, wrap, halt/resume,
// phase error recovery and mid-instruction reset.
module tb_pc_fetch_seq;
    import pc_seq_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       clk1, clk2, clk3, clk4, clk5;
    logic [7:0] mem_data;
    logic       branch_en;
    logic [7:0] branch_addr;
    logic       halt, resume;
    logic [7:0] pc, mem_addr, ir;
    logic       mem_rd, ir_valid, phase_err;
    logic [15:0] retired;

    int n_chk  = 0;
    int n_pass = 0;

    pc_fetch_seq #(.PC_W(8), .IR_W(8), .RESET_PC(8'h00)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .clk1        (clk1),
        .clk2        (clk2),
        .clk3        (clk3),
        .clk4        (clk4),
        .clk5        (clk5),
        .mem_data    (mem_data),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .retired     (retired),
        .phase_err   (phase_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge
    task automatic cyc(input logic [4:0] s);
        @(negedge clk_in);
        {clk5, clk4, clk3, clk2, clk1} = s;
        @(posedge clk_in);
        #1;
    endtask

    // Full 6-cycle frame; reports mem_addr after clk1, mem_rd after clk2,
    // ir/ir_valid after clk3
    task automatic frame(input logic [7:0] d, input logic be, input logic [7:0] ba,
                         input logic h, output logic [7:0] a, output logic r,
                         output logic [7:0] ir_o, output logic v);
        cyc(PH1); a = mem_addr;
        cyc(PH2); r = mem_rd; mem_data = d;
        cyc(PH3); ir_o = ir; v = ir_valid; branch_en = be; branch_addr = ba;
        cyc(PH4); branch_en = 1'b0; halt = h;
        cyc(PH5); halt = 1'b0;
        cyc(PH_NONE);
    endtask

    initial begin
        logic [7:0] a, iro;
        logic       r, v;
        int         rd_hits;

        rst = 1'b1;
        {clk5, clk4, clk3, clk2, clk1} = '0;
        mem_data = '0; branch_en = 1'b0; branch_addr = '0; halt = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_flags", {mem_rd, ir_valid, phase_err}, 3'b000);
        chk("rst_ret", retired, 16'd0);
        @(negedge clk_in); rst = 1'b0;

        // Lone non-clk1 strobe while waiting: ignored, no error
        cyc(PH3);
        chk("wait_ignore_err", phase_err, 1'b0);

        // Three clean frames
        frame(8'hA1, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("f1_addr", a, 8'h00); chk("f1_rd", r, 1'b1); chk("f1_ir", iro, 8'hA1); chk("f1_irv", v, 1'b1);
        frame(8'hA2, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("f2_addr", a, 8'h01); chk("f2_ir", iro, 8'hA2);
        frame(8'hA3, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("f3_addr", a, 8'h02); chk("f3_ir", iro, 8'hA3);
        chk("f3_pc", pc, 8'h03); chk("f3_ret", retired, 16'd3);
        chk("idle_clr", {mem_rd, ir_valid}, 2'b00);

        // Branch to 0x10, then 0x10 -> 0x40
        frame(8'h00, 1'b1, 8'h10, 1'b0, a, r, iro, v);
        chk("br10_pc", pc, 8'h10);
        frame(8'h00, 1'b1, 8'h40, 1'b0, a, r, iro, v);
        chk("br40_addr", a, 8'h10); chk("br40_pc", pc, 8'h40);
        // Fetch at 0x40, branch to 0xFF
        frame(8'h00, 1'b1, 8'hFF, 1'b0, a, r, iro, v);
        chk("at40_addr", a, 8'h40); chk("brFF_pc", pc, 8'hFF);
        // Wrap 0xFF -> 0x00
        frame(8'h00, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("wrap_pc", pc, 8'h00); chk("wrap_ret", retired, 16'd7);

        // Halt at pc 0x05
        frame(8'h00, 1'b1, 8'h05, 1'b0, a, r, iro, v);
        frame(8'h55, 1'b0, 8'h00, 1'b1, a, r, iro, v);
        chk("halt_pc", pc, 8'h06); chk("halt_ret", retired, 16'd9);
        rd_hits = 0;
        for (int f = 0; f < 10; f++) begin
            cyc(PH1); rd_hits += int'(mem_rd);
            cyc(PH2); rd_hits += int'(mem_rd);
            cyc(PH3); rd_hits += int'(mem_rd);
            cyc(PH4); cyc(PH5); cyc(PH_NONE);
        end
        chk("halted_rd", rd_hits, 0);
        chk("halted_pc", pc, 8'h06); chk("halted_ret", retired, 16'd9);
        chk("halted_ir", ir, 8'h55);
        @(negedge clk_in); resume = 1'b1;
        @(negedge clk_in); resume = 1'b0;
        frame(8'h66, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("resume_addr", a, 8'h06); chk("resume_pc", pc, 8'h07);

        // clk2 and clk3 together in RUN
        cyc(PH1);
        cyc(PH2 | PH3);
        chk("perr_set", phase_err, 1'b1);
        cyc(PH4); cyc(PH5); cyc(PH_NONE);
        chk("perr_pc", pc, 8'h07); chk("perr_ret", retired, 16'd10);
        frame(8'h77, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("perr_recov_addr", a, 8'h07); chk("perr_recov_pc", pc, 8'h08);
        chk("perr_sticky", phase_err, 1'b1);

        // Reset during clk4 of the instruction at 0x20
        frame(8'h00, 1'b1, 8'h20, 1'b0, a, r, iro, v);
        cyc(PH1); cyc(PH2); mem_data = 8'h99; cyc(PH3);
        @(negedge clk_in);
        {clk5, clk4, clk3, clk2, clk1} = PH4;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 8'h00); chk("mid_rst_ir", ir, 8'h00);
        chk("mid_rst_ret", retired, 16'd0); chk("mid_rst_err", phase_err, 1'b0);
        @(negedge clk_in); rst = 1'b0;
        cyc(PH5); cyc(PH_NONE);
        chk("post_rst_wait_pc", pc, 8'h00);
        frame(8'hB1, 1'b0, 8'h00, 1'b0, a, r, iro, v);
        chk("post_rst_addr", a, 8'h00); chk("post_rst_pc", pc, 8'h01);
        chk("post_rst_ir", iro, 8'hB1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

Interface
REQ-001 Parameter PC_W, default 8, program-counter and address width.
REQ-002 Parameter IR_W, default 8, instruction and memory-data width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Port clk_in  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Ports clk1..clk5  input  1 each  one-hot phase strobes from the phase generator; an idle slot with all low follows clk5.
REQ-007 Port mem_data  input  IR_W  instruction memory read data, valid during the clk3 cycle.
REQ-008 Port branch_en  input  1  branch request, sampled in the clk4 cycle.
REQ-009 Port branch_addr  input  PC_W  branch target, sampled with branch_en.
REQ-010 Port halt  input  1  stop request, sampled in the clk5 cycle.
REQ-011 Port resume  input  1  leave HALTED, level-sampled every cycle.
REQ-012 Port pc  output  PC_W  current program counter.
REQ-013 Port mem_addr  output  PC_W  registered instruction-fetch address.
REQ-014 Port mem_rd  output  1  memory read enable.
REQ-015 Port ir  output  IR_W  instruction register.
REQ-016 Port ir_valid  output  1  one-cycle pulse when ir is loaded.
REQ-017 Port retired  output  16  count of completed instructions.
REQ-018 Port phase_err  output  1  sticky phase-sequence error flag.

Function
REQ-019 FSM states WAIT_PH1, RUN, HALTED; the block SHALL leave WAIT_PH1 for RUN only on a cycle where clk1 is high and no other strobe is high.
REQ-020 The clk1 cycle that enters or occurs in RUN SHALL register mem_addr <= pc, with mem_addr visible the next cycle (clk2 cycle).
REQ-021 mem_rd SHALL be 1 exactly in the cycle after clk2 is sampled high in RUN (the clk3 cycle), and 0 otherwise.
REQ-022 On clk3 in RUN, ir SHALL load mem_data and ir_valid SHALL pulse high for exactly the following cycle.
REQ-023 On clk4 in RUN, branch_en and branch_addr SHALL be captured into a pending-target register.
REQ-024 On clk5 in RUN, pc SHALL become the pending target if captured branch_en=1, else pc+1 modulo 2^PC_W (0xFF -> 0x00 at PC_W=8); retired SHALL increment, wrapping 0xFFFF -> 0x0000.
REQ-025 On clk5 with halt=1, the PC update and retire SHALL still complete, then FSM SHALL enter HALTED.
REQ-026 In HALTED all strobes SHALL be ignored, mem_rd=0, pc/ir held; resume=1 SHALL move to WAIT_PH1 (resynchronise on next clk1).
REQ-027 Phase error, in RUN: more than one strobe high in a cycle, or a strobe other than the expected next one (clk1->clk2->clk3->clk4->clk5->clk1) high. Then phase_err SHALL set, the current instruction SHALL be abandoned without pc/retired update, FSM SHALL go to WAIT_PH1.
REQ-028 Multiple strobes high in WAIT_PH1 SHALL also set phase_err; single non-clk1 strobes there SHALL be ignored without error.
REQ-029 phase_err SHALL clear only on reset.
REQ-030 Idle (all-low) cycles SHALL never change state or outputs except clearing ir_valid/mem_rd.

Reset
REQ-031 While rst=1: FSM=WAIT_PH1, pc=RESET_PC, mem_addr=RESET_PC, ir=0, pending target=0, ir_valid=0, mem_rd=0, retired=0, phase_err=0.
REQ-032 Reset asserted mid-instruction SHALL abort it immediately with no partial pc update.

Structure
REQ-033 Shared package pc_seq_pkg SHALL hold the FSM state encoding, default PC_W/IR_W and the phase one-hot constants.
REQ-034 One sub-module, phase_check, SHALL compute one-hot and expected-order violation combinationally from the strobes and the last accepted phase.

Verification
REQ-035 Reset then 3 clean 6-cycle frames, mem_data=0xA1,0xA2,0xA3 -> mem_addr 0x00,0x01,0x02; ir sequence A1,A2,A3; pc=0x03; retired=3.
REQ-036 pc=0x10, branch_en=1, branch_addr=0x40 in clk4 -> pc=0x40 after clk5; next mem_addr=0x40.
REQ-037 PC_W=8, pc=0xFF, no branch -> pc=0x00 after clk5, retired increments.
REQ-038 halt=1 in clk5 at pc=0x05 -> pc=0x06, HALTED, mem_rd=0 for 10 frames; resume=1 -> fetch from 0x06 on next clk1.
REQ-039 clk2 and clk3 both high in RUN -> phase_err=1, pc unchanged, recovery on next clean clk1; phase_err stays 1.
REQ-040 rst pulsed during clk4 of pc=0x20 -> pc=RESET_PC, ir=0, retired=0, FSM waits for clk1.
